// File: rtl/muldiv_pkg.sv
// Shared op encodings and sequencer states for the multiply/divide unit.
// The CPU control FSM imports the same OP_* constants.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done request bus between the CPU and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? ((~din) + WIDTH'(1'b1)) : din;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply / restoring divide producing a 2*WIDTH hi/lo result.
// Optional macro MULDIV_EARLY_TERM_EN: multiply RUN ends once the remaining multiplier is zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start
  // PREP  | operand magnitudes, result signs, divide-by-zero detect
  // RUN   | one multiplier / quotient bit per cycle
  // FIX   | sign correction, load hi/lo
  // DONE  | done pulse; start here chains the next operation
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_PREP = PREP;
  localparam logic [2:0] S_RUN  = RUN;
  localparam logic [2:0] S_FIX  = FIX;
  localparam logic [2:0] S_DONE = DONE;

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dbz_q, dbz_d;
  logic               dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               mul_early;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg  (is_signed & a_q[WIDTH-1]),
    .din  (a_q),
    .dout (mag_a)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg  (is_signed & b_q[WIDTH-1]),
    .din  (b_q),
    .dout (mag_b)
  );

  // Shift-add: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ({WIDTH{mb_q[0]}} & ma_q)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: remainder in the upper half, dividend shifting out / quotient shifting in below.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_TERM_EN
  // On early exit cnt_q holds the number of right shifts still owed to the partial product.
  assign mul_early = !is_div && (mb_q[WIDTH-1:1] == '0);
  assign prod_raw  = acc_q >> cnt_q;
`else
  assign mul_early = 1'b0;
  assign prod_raw  = acc_q;
`endif

  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .neg  (neg_lo_q),
    .din  (prod_raw),
    .dout (prod_fix)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .neg  (neg_lo_q),
    .din  (acc_q[WIDTH-1:0]),
    .dout (quo_fix)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .neg  (neg_hi_q),
    .din  (acc_q[2*WIDTH-1:WIDTH]),
    .dout (rem_fix)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dbz_d     = dbz_q;
    dbz_out_d = dbz_out_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          op_d      = bus.op;
          dbz_out_d = 1'b0;
          state_d   = S_PREP;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_PREP: begin
        ma_d     = mag_a;
        mb_d     = mag_b;
        cnt_d    = CNT_LAST;
        neg_lo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        if (is_div) begin
          neg_hi_d = is_signed & a_q[WIDTH-1];
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          dbz_d    = (b_q == '0);
          state_d  = (b_q == '0) ? S_FIX : S_RUN;
        end else begin
          neg_hi_d = 1'b0;
          acc_d    = '0;
          dbz_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div) begin
          acc_d = div_next;
        end else begin
          acc_d = mul_next;
          mb_d  = mb_q >> 1;
        end
        if ((cnt_q == '0) || mul_early) begin
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        if (dbz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        dbz_out_d = dbz_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dbz_q     <= dbz_d;
      dbz_out_q <= dbz_out_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq at WIDTH=32: vector table, corner sequences, random vs. arithmetic model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) mif ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values; latency from the cycle budget rules.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic dbz, output int lat);
    logic [63:0] p;
    longint      sa, sb, q, r, mag;
    int          nbits;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    lat = W + 3;
    p   = '0;
    case (op)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          dbz = 1'b1;
          lat = 3;
          p   = {a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
`ifdef MULDIV_EARLY_TERM_EN
    if (op == OP_MULT || op == OP_MULTU) begin
      mag   = (op == OP_MULT && sb < 0) ? -sb : longint'({32'b0, b});
      nbits = 0;
      while (mag != 0) begin
        mag = mag >> 1;
        nbits++;
      end
      lat = 3 + ((nbits < 1) ? 1 : nbits);
    end
`endif
    hi = p[63:32];
    lo = p[31:0];
  endtask

  // Call at a negedge; returns at the negedge where done is seen (DONE state).
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit pulse_while_busy, output int lat,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    int busy_bad;
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    lat       = 0;
    busy_bad  = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        mif.start = 1'b0;
        check("dbz_cleared_on_start", 64'(mif.div_by_zero), 64'd0);
      end
      if (pulse_while_busy && lat == 2) begin
        mif.start = 1'b1;
        mif.op    = OP_MULTU;
        mif.a     = 32'h1111_1111;
        mif.b     = 32'h2222_2222;
      end
      if (pulse_while_busy && lat == 3) mif.start = 1'b0;
      if (mif.done) break;
      if (!mif.busy) busy_bad++;
    end
    if (lat >= 200) check("done_timeout", 64'(lat), 64'd0);
    check("busy_profile", 64'(busy_bad), 64'd0);
    check("busy_low_at_done", 64'(mif.busy), 64'd0);
    hi  = mif.hi;
    lo  = mif.lo;
    dbz = mif.div_by_zero;
  endtask

  task automatic run_checked(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit pulse);
    logic [W-1:0] hi, lo, ehi, elo;
    logic         dbz, edbz;
    int           lat, elat;
    model(op, a, b, ehi, elo, edbz, elat);
    do_op(op, a, b, pulse, lat, hi, lo, dbz);
    if (hi !== ehi || lo !== elo || dbz !== edbz || lat != elat)
      $display("  %s op=%0d a=%h b=%h", tag, op, a, b);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dbz"}, 64'(dbz), 64'(edbz));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] hi, lo, ehi, elo;
    logic         dbz, edbz;
    int           lat, elat, extra;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{OP_MULTU, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[9] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

    reset     = 1'b1;
    mif.start = 1'b0;
    mif.op    = OP_MULT;
    mif.a     = '0;
    mif.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    check("rst_hi", 64'(mif.hi), 64'd0);
    check("rst_lo", 64'(mif.lo), 64'd0);
    check("rst_dbz", 64'(mif.div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors; each start is issued in the DONE cycle of the previous op (back-to-back).
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, ehi, elo, edbz, elat);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, hi, lo, dbz);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(elat));
    end

    // Explicit latencies for the spec-named cases.
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, hi, lo, dbz);
    check("mult_latency_35", 64'(lat), 64'd35);
    do_op(OP_DIVU, 32'h1234, 32'd0, 1'b0, lat, hi, lo, dbz);
    check("dbz_latency_3", 64'(lat), 64'd3);
    do_op(OP_MULTU, 32'd5, 32'd3, 1'b0, lat, hi, lo, dbz);
`ifdef MULDIV_EARLY_TERM_EN
    check("early_term_latency", 64'(lat), 64'd5);
`else
    check("full_run_latency", 64'(lat), 64'd35);
`endif

    // Start pulse while busy must be ignored and produce no extra done.
    run_checked("busy_pulse", OP_DIVU, 32'd100, 32'd7, 1'b1);
    extra = 0;
    repeat (45) begin
      @(negedge clk);
      if (mif.done) extra++;
    end
    check("no_extra_done", 64'(extra), 64'd0);

    // Reset during RUN cycle 10 discards the operation.
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, hi, lo, dbz);
    mif.start = 1'b1;
    mif.op    = OP_MULTU;
    mif.a     = 32'hFFFF_FFFF;
    mif.b     = 32'hFFFF_FFFF;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) mif.start = 1'b0;
    end
    check("pre_reset_busy", 64'(mif.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(mif.busy), 64'd0);
    check("mid_rst_done", 64'(mif.done), 64'd0);
    check("mid_rst_hi", 64'(mif.hi), 64'd0);
    check("mid_rst_lo", 64'(mif.lo), 64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (45) begin
      @(negedge clk);
      if (mif.done) extra++;
    end
    check("no_done_after_reset", 64'(extra), 64'd0);

    // Randomised operations against the model, with occasional idle gaps.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_checked($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
